card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 142 ++++++++++++++
 tb/tb_card_dealer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card dealer: deals 9 distinct cards (0..51) drawn from a 16-bit LFSR over a valid/ready handshake.
// Optional: define CARD_DEALER_REJECT_CNT_EN to add the reject_cnt output.
module card_dealer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        abort,
    input  logic        card_ready,
    output logic        card_valid,
    output logic [5:0]  card_code,
    output logic [3:0]  card_number,
    output logic [1:0]  card_flower,
    output logic [3:0]  card_index,
    output logic        busy,
`ifdef CARD_DEALER_REJECT_CNT_EN
    output logic [7:0]  reject_cnt,
`endif
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start
    // DRAW  | testing lfsr[5:0] each cycle until an unused code < 52 appears
    // OFFER | card presented, waiting for card_ready
    // DONE  | one-cycle done pulse after slot 8 is accepted
    typedef enum logic [1:0] {IDLE, DRAW, OFFER, DONE} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_lfsr;
    logic [51:0] r_used;
    logic [5:0]  r_code;
    logic [3:0]  r_index;
    logic [5:0]  w_cand;
    logic        w_cand_ok;
    logic        w_accept;
    logic        w_feedback;

    assign w_cand     = r_lfsr[5:0];
    assign w_cand_ok  = (w_cand < 6'd52);
    assign w_accept   = w_cand_ok && !r_used[w_cand];
    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // A zero seed would lock the LFSR, so it is replaced by the reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_INIT;
        end else if (seed_load) begin
            r_lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        card_valid   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = DRAW;
            end
            DRAW: begin
                if (abort)         w_state_next = IDLE;
                else if (w_accept) w_state_next = OFFER;
            end
            OFFER: begin
                card_valid = 1'b1;
                if (abort)           w_state_next = IDLE;
                else if (card_ready) w_state_next = (r_index == 4'd8) ? DONE : DRAW;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= 6'd0;
            r_index <= 4'd0;
            r_used  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_used  <= '0;
                        r_index <= 4'd0;
                    end
                end
                DRAW: begin
                    if (!abort && w_accept) begin
                        r_code         <= w_cand;
                        r_used[w_cand] <= 1'b1;
                    end
                end
                OFFER: begin
                    if (!abort && card_ready && (r_index != 4'd8)) r_index <= r_index + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CARD_DEALER_REJECT_CNT_EN
    logic [7:0] r_reject_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reject_cnt <= 8'd0;
        end else if ((r_state == IDLE) && start) begin
            r_reject_cnt <= 8'd0;
        end else if ((r_state == DRAW) && !abort && !w_accept && (r_reject_cnt != 8'hFF)) begin
            r_reject_cnt <= r_reject_cnt + 8'd1;
        end
    end

    assign reject_cnt = r_reject_cnt;
`endif

    assign card_code   = r_code;
    assign card_number = r_code[5:2];
    assign card_flower = r_code[1:0];
    assign card_index  = r_index;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a transaction-level dealer model predicts each card from the
// LFSR stream; a negedge monitor pops expectations on every handshake and done pulse.
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        abort = 1'b0;
    logic        card_ready = 1'b0;
    logic        card_valid;
    logic [5:0]  card_code;
    logic [3:0]  card_number;
    logic [1:0]  card_flower;
    logic [3:0]  card_index;
    logic        busy;
    logic        done;
`ifdef CARD_DEALER_REJECT_CNT_EN
    logic [7:0]  reject_cnt;
`endif

    card_dealer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed_load   (seed_load),
        .seed        (seed),
        .abort       (abort),
        .card_ready  (card_ready),
        .card_valid  (card_valid),
        .card_code   (card_code),
        .card_number (card_number),
        .card_flower (card_flower),
        .card_index  (card_index),
        .busy        (busy),
`ifdef CARD_DEALER_REJECT_CNT_EN
        .reject_cnt  (reject_cnt),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        int code;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    int          hs_codes[$];
    logic [15:0] m_lfsr;
    logic [51:0] dealt_map;
    bit          prev_hold = 1'b0;
    logic [5:0]  prev_code;
    logic [3:0]  prev_idx;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR value: what the generator holds during the current cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst)           m_lfsr <= 16'hACE1;
        else if (seed_load) m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else                m_lfsr <= lfsr_next(m_lfsr);
    end

    // Monitor: handshakes and done pulses are checked against the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            if (start && !busy) dealt_map = '0;
            if (prev_hold) begin
                chk(card_valid == 1'b1, "hold_valid", int'(card_valid), 1);
                chk(card_code == prev_code, "hold_code", int'(card_code), int'(prev_code));
                chk(card_index == prev_idx, "hold_index", int'(card_index), int'(prev_idx));
            end
            if (card_valid && card_ready && !abort) begin
                hs_codes.push_back(int'(card_code));
                if (exp_q.size() == 0) begin
                    chk(1'b0, "hs_unexpected", int'(card_index), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(!e.is_done, "hs_kind", 1, 0);
                    chk(int'(card_code) == e.code, "hs_code", int'(card_code), e.code);
                    chk(int'(card_index) == e.idx, "hs_index", int'(card_index), e.idx);
                end
                chk(card_code < 6'd52, "code_range", int'(card_code), 51);
                chk(card_number == card_code[5:2], "card_number", int'(card_number), int'(card_code[5:2]));
                chk(card_flower == card_code[1:0], "card_flower", int'(card_flower), int'(card_code[1:0]));
                if (card_code < 6'd52) begin
                    chk(!dealt_map[card_code], "code_distinct", int'(card_code), -1);
                    dealt_map[card_code] = 1'b1;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.is_done, "done_kind", 1, 0);
                end
            end
            prev_hold = card_valid && !card_ready && !abort;
            prev_code = card_code;
            prev_idx  = card_index;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // One deal. Each card is predicted by scanning the LFSR stream from the cycle its draw begins.
    task automatic deal(input bit ld, input logic [15:0] sd, input bit rnd_rdy,
                        input int stall_at, input int abort_at, input int rst_at);
        logic [51:0] used;
        logic [15:0] l;
        logic [5:0]  cand;
        int          n;
        int          draws;
        int          w;
        bit          rdy;
        exp_t        e;
        used  = '0;
        draws = 0;
        cand  = 6'd0;
        start = 1'b1;
        seed_load = ld;
        seed = sd;
        card_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        tick;
        start = 1'b0;
        seed_load = 1'b0;
        chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
        chk(card_valid == 1'b0, "valid_in_first_draw", int'(card_valid), 0);
`ifdef CARD_DEALER_REJECT_CNT_EN
        chk(reject_cnt == 8'd0, "reject_cnt_cleared", int'(reject_cnt), 0);
`endif
        for (int k = 0; k < 9; k++) begin
            l = m_lfsr;
            n = 1;
            while (!((l[5:0] < 6'd52) && !used[l[5:0]])) begin
                l = lfsr_next(l);
                n++;
                if (n > 5000) begin
                    $display("FAIL draw_bound: got %0d, want <5000", n);
                    $fatal(1);
                end
            end
            cand = l[5:0];
            used[cand] = 1'b1;
            draws += n;
            repeat (n) begin
                card_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
                tick;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                card_ready = 1'b1;
                tick;
                abort = 1'b0;
                card_ready = 1'b0;
                chk(busy == 1'b0, "abort_busy", int'(busy), 0);
                chk(card_valid == 1'b0, "abort_valid", int'(card_valid), 0);
                chk(done == 1'b0, "abort_done", int'(done), 0);
                tick;
                chk(card_valid == 1'b0, "abort_no_next", int'(card_valid), 0);
                return;
            end
            if (k == rst_at) begin
                chk(card_valid == 1'b1, "pre_reset_offer", int'(card_valid), 1);
                rst = 1'b0;
                start = 1'b1;
                #1;
                chk(card_valid == 1'b0, "reset_valid", int'(card_valid), 0);
                chk(busy == 1'b0, "reset_busy", int'(busy), 0);
                chk(done == 1'b0, "reset_done", int'(done), 0);
                tick;
                tick;
                chk(busy == 1'b0, "reset_start_ignored", int'(busy), 0);
                start = 1'b0;
                #2;
                rst = 1'b1;
                tick;
                chk(busy == 1'b0, "post_reset_idle", int'(busy), 0);
                chk(card_index == 4'd0, "post_reset_index", int'(card_index), 0);
                return;
            end
            w = 0;
            do begin
                if (k == stall_at && w < 5) rdy = 1'b0;
                else if (k == stall_at)     rdy = 1'b1;
                else if (rnd_rdy && w < 20) rdy = ($urandom_range(0, 1) == 1);
                else                        rdy = 1'b1;
                card_ready = rdy;
                if (rdy) begin
                    e.is_done = 1'b0;
                    e.idx = k;
                    e.code = int'(cand);
                    exp_q.push_back(e);
                    if (k == 8) begin
                        e.is_done = 1'b1;
                        e.idx = 8;
                        e.code = 0;
                        exp_q.push_back(e);
                    end
                end
                tick;
                w++;
            end while (!rdy);
        end
        card_ready = 1'b0;
        chk(card_index == 4'd8, "done_index_held", int'(card_index), 8);
        chk(card_code == cand, "done_code_held", int'(card_code), int'(cand));
        chk(card_valid == 1'b0, "done_valid", int'(card_valid), 0);
        tick;
        chk(busy == 1'b0, "idle_after_done", int'(busy), 0);
        chk(done == 1'b0, "done_one_cycle", int'(done), 0);
`ifdef CARD_DEALER_REJECT_CNT_EN
        chk(int'(reject_cnt) == ((draws - 9) > 255 ? 255 : (draws - 9)), "reject_cnt",
            int'(reject_cnt), ((draws - 9) > 255 ? 255 : (draws - 9)));
`endif
    endtask

    task automatic compare_runs(input int a[$], input int b[$], input string name);
        chk(a.size() == 9, {name, "_len_a"}, a.size(), 9);
        chk(b.size() == 9, {name, "_len_b"}, b.size(), 9);
        if (a.size() == 9 && b.size() == 9) begin
            for (int i = 0; i < 9; i++) chk(a[i] == b[i], name, b[i], a[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int run_a[$];
        int run_b[$];
        #12;
        chk(card_valid == 1'b0, "rst_valid", int'(card_valid), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(done == 1'b0, "rst_done", int'(done), 0);
        chk(card_code == 6'd0, "rst_code", int'(card_code), 0);
        chk(card_index == 4'd0, "rst_index", int'(card_index), 0);
`ifdef CARD_DEALER_REJECT_CNT_EN
        chk(reject_cnt == 8'd0, "rst_reject_cnt", int'(reject_cnt), 0);
`endif
        rst = 1'b1;
        tick;
        tick;

        deal(1'b1, 16'h0001, 1'b0, -1, -1, -1);
        tick;

        hs_codes.delete();
        deal(1'b1, 16'h1234, 1'b0, -1, -1, -1);
        run_a = hs_codes;
        tick;
        tick;
        hs_codes.delete();
        deal(1'b1, 16'h1234, 1'b0, -1, -1, -1);
        run_b = hs_codes;
        compare_runs(run_a, run_b, "seed_repeat");

        hs_codes.delete();
        deal(1'b1, 16'h0000, 1'b0, -1, -1, -1);
        run_a = hs_codes;
        tick;
        hs_codes.delete();
        deal(1'b1, 16'hACE1, 1'b0, -1, -1, -1);
        run_b = hs_codes;
        compare_runs(run_a, run_b, "seed_zero");

        deal(1'b1, 16'($urandom), 1'b1, 3, -1, -1);
        tick;
        deal(1'b1, 16'($urandom), 1'b1, -1, 2, -1);
        tick;
        deal(1'b0, 16'h0000, 1'b1, -1, -1, 5);
        tick;

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) tick;
            deal($urandom_range(0, 1) == 1, 16'($urandom), 1'b1, -1, -1, -1);
        end

        tick;
        tick;
        chk(exp_q.size() == 0, "queue_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
